// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU operation encoding,
// RV32I major opcodes, the buffered issue entry and the skid buffer states.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111
   } alu_op_e;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      alu_op_e     op;
      logic        illegal;
   } issue_entry_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_FULL  = 2'b10
   } buf_state_e;

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate extraction: I-type and S-type sign-extended,
// U-type upper immediate. Opcode bits are not needed, so they are not ported in.
module alu_imm_gen (
   input  logic [31:7] i_instr,
   output logic [31:0] o_imm_i,
   output logic [31:0] o_imm_s,
   output logic [31:0] o_imm_u
);

   assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign o_imm_u = {i_instr[31:12], 12'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the integer ALU. Decodes the incoming
// instruction into ALU operands/operation and queues the result in a two-entry
// skid buffer so in_ready_o comes only from registered state.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] alu_op1_o,
   output logic [31:0] alu_op2_o,
   output logic [3:0]  alu_operation_o,
   output logic        illegal_o
);

   logic [6:0]   w_opcode;
   logic [2:0]   w_funct3;
   logic [6:0]   w_funct7;
   logic [31:0]  w_imm_i;
   logic [31:0]  w_imm_s;
   logic [31:0]  w_imm_u;
   logic         w_legal;
   issue_entry_t w_dec;

   buf_state_e   r_state;
   buf_state_e   w_state_nxt;
   issue_entry_t r_head;
   issue_entry_t r_skid;
   logic         w_acc;
   logic         w_pop;
   logic         w_load_head;
   logic         w_head_from_skid;
   logic         w_load_skid;

   assign w_opcode = instr_i[6:0];
   assign w_funct3 = instr_i[14:12];
   assign w_funct7 = instr_i[31:25];

   alu_imm_gen u_imm_gen (
      .i_instr (instr_i[31:7]),
      .o_imm_i (w_imm_i),
      .o_imm_s (w_imm_s),
      .o_imm_u (w_imm_u)
   );

   // Decode the incoming instruction into an issue entry; illegal entries are zeroed.
   always_comb begin
      // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
      w_dec   = '0;
      w_legal = 1'b1;
      case (w_opcode)
         OP: begin
            w_dec.op1 = rs1_data_i;
            w_dec.op2 = rs2_data_i;
            w_dec.op  = alu_op_e'({w_funct7[5], w_funct3});
            if (!((w_funct7 == 7'h00) ||
                  ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))))
               w_legal = 1'b0;
         end
         OP_IMM: begin
            w_dec.op1 = rs1_data_i;
            w_dec.op2 = w_imm_i;
            w_dec.op  = alu_op_e'({1'b0, w_funct3});
            if (w_funct3 == 3'b001) begin
               w_dec.op2 = {27'b0, instr_i[24:20]};
               if (w_funct7 != 7'h00) w_legal = 1'b0;
            end else if (w_funct3 == 3'b101) begin
               w_dec.op2 = {27'b0, instr_i[24:20]};
               w_dec.op  = alu_op_e'({w_funct7[5], w_funct3});
               if ((w_funct7 != 7'h00) && (w_funct7 != 7'h20)) w_legal = 1'b0;
            end
         end
         LUI: begin
            w_dec.op2 = w_imm_u;
            w_dec.op  = ALU_ADD;
         end
         AUIPC: begin
            w_dec.op1 = pc_i;
            w_dec.op2 = w_imm_u;
            w_dec.op  = ALU_ADD;
         end
         LOAD: begin
            w_dec.op1 = rs1_data_i;
            w_dec.op2 = w_imm_i;
            w_dec.op  = ALU_ADD;
         end
         STORE: begin
            w_dec.op1 = rs1_data_i;
            w_dec.op2 = w_imm_s;
            w_dec.op  = ALU_ADD;
         end
         BRANCH: begin
            w_dec.op1 = rs1_data_i;
            w_dec.op2 = rs2_data_i;
            case (w_funct3)
               3'b000, 3'b001: w_dec.op = ALU_SUB;   // equality via zero flag
               3'b100, 3'b101: w_dec.op = ALU_SLT;
               3'b110, 3'b111: w_dec.op = ALU_SLTU;
               default:        w_legal  = 1'b0;
            endcase
         end
         JAL, JALR: begin
            w_dec.op1 = pc_i;
            w_dec.op2 = 32'd4;
            w_dec.op  = ALU_ADD;
         end
         default: w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
      end
   end

   assign in_ready_o  = (r_state != BUF_FULL);
   assign out_valid_o = (r_state != BUF_EMPTY);
   assign w_acc       = in_valid_i & in_ready_o;
   assign w_pop       = out_valid_o & out_ready_i;

   // Skid buffer state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_ni) r_state <= BUF_EMPTY;
      else         r_state <= w_state_nxt;
   end

   // Next state and payload load controls; flush overrides accept and pop.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_head      = 1'b0;
      w_head_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush_i) begin
         w_state_nxt = BUF_EMPTY;
      end else begin
         case (r_state)
            BUF_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt = BUF_ONE;
                  w_load_head = 1'b1;
               end
            end
            BUF_ONE: begin
               if (w_acc && !w_pop) begin
                  w_state_nxt = BUF_FULL;
                  w_load_skid = 1'b1;
               end else if (w_acc && w_pop) begin
                  w_load_head = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (w_pop) begin
                  w_state_nxt      = BUF_ONE;
                  w_load_head      = 1'b1;
                  w_head_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = BUF_EMPTY;
         endcase
      end
   end

   // Head entry register; drives the ALU-facing outputs and is cleared on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          r_head <= '0;
      else if (w_load_head) r_head <= w_head_from_skid ? r_skid : w_dec;
   end

   // Skid entry register, written only when the head is occupied and stalled.
   // NOTE: no reset here; the skid is never observed before it has been written.
   always_ff @(posedge clk_i) begin
      if (w_load_skid) r_skid <= w_dec;
   end

   assign alu_op1_o       = r_head.op1;
   assign alu_op2_o       = r_head.op2;
   assign alu_operation_o = r_head.op;
   assign illegal_o       = r_head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode vectors, skid buffer
// corner sequences, asynchronous reset, then randomized traffic against a
// queue-based reference model.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  op;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  op;
      logic        ill;
   } vec_t;

   localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b1000, C_SLT = 4'b0010, C_SLTU = 4'b0011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr, pc, rs1, rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1, op2;
   logic [3:0]  op;
   logic        ill;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t q[$];
   vec_t vecs[16];

   alu_issue_stage dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .flush_i         (flush),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .instr_i         (instr),
      .pc_i            (pc),
      .rs1_data_i      (rs1),
      .rs2_data_i      (rs2),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .alu_op1_o       (op1),
      .alu_op2_o       (op2),
      .alu_operation_o (op),
      .illegal_o       (ill)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_head(input string name, input exp_t e);
      check({name, " valid"}, {31'b0, out_valid}, 32'd1);
      check({name, " op1"}, op1, e.op1);
      check({name, " op2"}, op2, e.op2);
      check({name, " op"}, {28'b0, op}, {28'b0, e.op});
      check({name, " illegal"}, {31'b0, ill}, {31'b0, e.ill});
   endtask

   // Reference decode straight from the instruction-class rules.
   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b);
      logic [2:0]  f3    = ins[14:12];
      logic [6:0]  f7    = ins[31:25];
      logic [31:0] imm_i = $unsigned($signed(ins) >>> 20);
      logic [31:0] imm_s = (imm_i & ~32'h1F) | {27'b0, ins[11:7]};
      logic [31:0] imm_u = ins & 32'hFFFF_F000;
      logic [31:0] shamt = {27'b0, ins[24:20]};
      bit          ok    = 1;
      exp_t        r     = '0;
      case (ins[6:0])
         7'h33: begin
            r  = '{a, b, {f7[5], f3}, 1'b0};
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         7'h13: begin
            if (f3 == 3'd1)      begin r = '{a, shamt, {1'b0, f3}, 1'b0}; ok = (f7 == 0); end
            else if (f3 == 3'd5) begin r = '{a, shamt, {f7[5], f3}, 1'b0}; ok = (f7 == 0 || f7 == 7'h20); end
            else                       r = '{a, imm_i, {1'b0, f3}, 1'b0};
         end
         7'h37: r = '{32'd0, imm_u, C_ADD, 1'b0};
         7'h17: r = '{p, imm_u, C_ADD, 1'b0};
         7'h03: r = '{a, imm_i, C_ADD, 1'b0};
         7'h23: r = '{a, imm_s, C_ADD, 1'b0};
         7'h63: begin
            if (f3 == 3'd2 || f3 == 3'd3) ok = 0;
            else r = '{a, b, (f3 < 3'd4) ? C_SUB : (f3 < 3'd6) ? C_SLT : C_SLTU, 1'b0};
         end
         7'h6F, 7'h67: r = '{p, 32'd4, C_ADD, 1'b0};
         default: ok = 0;
      endcase
      if (!ok) r = '{32'd0, 32'd0, C_ADD, 1'b1};
      return r;
   endfunction

   task automatic drive(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
      instr = i; pc = p; rs1 = a; rs2 = b;
   endtask

   initial begin
      vecs[0]  = '{32'h40415093, 32'h0,   32'h80000000, 32'h1234, 32'h80000000, 32'h4,        4'hD, 1'b0}; // SRAI
      vecs[1]  = '{32'h20415093, 32'h0,   32'h80000000, 32'h1234, 32'h0,        32'h0,        4'h0, 1'b1}; // SRAI f7=0x10
      vecs[2]  = '{32'h12345097, 32'h100, 32'hDEAD,     32'hBEEF, 32'h100,      32'h12345000, 4'h0, 1'b0}; // AUIPC
      vecs[3]  = '{32'h0020E063, 32'h0,   32'h7,        32'h9,    32'h7,        32'h9,        4'h3, 1'b0}; // BLTU
      vecs[4]  = '{32'h00208063, 32'h0,   32'h7,        32'h7,    32'h7,        32'h7,        4'h8, 1'b0}; // BEQ
      vecs[5]  = '{32'h40000033, 32'h0,   32'h5,        32'h3,    32'h5,        32'h3,        4'h8, 1'b0}; // SUB
      vecs[6]  = '{32'hFFF10093, 32'h0,   32'h10,       32'h0,    32'h10,       32'hFFFFFFFF, 4'h0, 1'b0}; // ADDI -1
      vecs[7]  = '{32'hFE312E23, 32'h0,   32'h1000,     32'h55,   32'h1000,     32'hFFFFFFFC, 4'h0, 1'b0}; // SW -4
      vecs[8]  = '{32'hABCDE0B7, 32'h0,   32'h11,       32'h22,   32'h0,        32'hABCDE000, 4'h0, 1'b0}; // LUI
      vecs[9]  = '{32'h0000006F, 32'h200, 32'h11,       32'h22,   32'h200,      32'h4,        4'h0, 1'b0}; // JAL
      vecs[10] = '{32'h0000007F, 32'h300, 32'h11,       32'h22,   32'h0,        32'h0,        4'h0, 1'b1}; // bad opcode
      vecs[11] = '{32'h0020A063, 32'h0,   32'h11,       32'h22,   32'h0,        32'h0,        4'h0, 1'b1}; // BRANCH f3=010
      vecs[12] = '{32'h40001033, 32'h0,   32'h11,       32'h22,   32'h0,        32'h0,        4'h0, 1'b1}; // OP f7=0x20 SLL
      vecs[13] = '{32'h0020C0B3, 32'h0,   32'hF0F0,     32'h0FF0, 32'hF0F0,     32'h0FF0,     4'h4, 1'b0}; // XOR
      vecs[14] = '{32'h40311093, 32'h0,   32'h11,       32'h22,   32'h0,        32'h0,        4'h0, 1'b1}; // SLLI f7=0x20
      vecs[15] = '{32'h00812083, 32'h0,   32'h100,      32'h22,   32'h100,      32'h8,        4'h0, 1'b0}; // LW 8

      // Reset with a SUB presented and held valid.
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      drive(32'h40000033, 32'h0, 32'd5, 32'd3);
      repeat (2) @(negedge clk);
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset op1", op1, 32'd0);
      check("reset op2", op2, 32'd0);
      check("reset op", {28'b0, op}, 32'd0);
      check("reset illegal", {31'b0, ill}, 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check_head("first sub", '{32'd5, 32'd3, C_SUB, 1'b0});
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("drain after reset", {31'b0, out_valid}, 32'd0);

      // Directed decode vectors at full throughput.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         in_valid = 1'b1;
         @(negedge clk);
         check_head($sformatf("vec%0d", i), '{vecs[i].op1, vecs[i].op2, vecs[i].op, vecs[i].ill});
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("vec drain", {31'b0, out_valid}, 32'd0);

      // Backpressure: A, B fill the buffer, C is refused, drain gives A then B.
      out_ready = 1'b0; in_valid = 1'b1;
      drive(32'h40000033, 32'h0, 32'd1, 32'd2);     // A = SUB 1,2
      @(negedge clk);
      check("bp one in_ready", {31'b0, in_ready}, 32'd1);
      check_head("bp head A", '{32'd1, 32'd2, C_SUB, 1'b0});
      drive(32'h0020C0B3, 32'h0, 32'd3, 32'd4);     // B = XOR 3,4
      @(negedge clk);
      check("bp full in_ready", {31'b0, in_ready}, 32'd0);
      check_head("bp still A", '{32'd1, 32'd2, C_SUB, 1'b0});
      drive(32'hFFF10093, 32'h0, 32'd9, 32'd9);     // C = ADDI, must be refused
      @(negedge clk);
      check("bp stall in_ready", {31'b0, in_ready}, 32'd0);
      check_head("bp stall A", '{32'd1, 32'd2, C_SUB, 1'b0});
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_head("bp head B", '{32'd3, 32'd4, 4'h4, 1'b0});
      check("bp after pop in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      check("bp empty", {31'b0, out_valid}, 32'd0);

      // Flush in ONE with a same-cycle accept, then flush in FULL.
      out_ready = 1'b0; in_valid = 1'b1;
      drive(32'h40000033, 32'h0, 32'd1, 32'd2);
      @(negedge clk);
      drive(32'h0020C0B3, 32'h0, 32'd7, 32'd8);
      flush = 1'b1;
      @(negedge clk);
      check("flush one out_valid", {31'b0, out_valid}, 32'd0);
      check("flush one in_ready", {31'b0, in_ready}, 32'd1);
      flush = 1'b0;
      drive(32'h40000033, 32'h0, 32'd1, 32'd2);
      @(negedge clk);
      drive(32'h0020C0B3, 32'h0, 32'd3, 32'd4);
      @(negedge clk);
      check("pre-flush full", {31'b0, in_ready}, 32'd0);
      drive(32'hFFF10093, 32'h0, 32'd9, 32'd9);
      flush = 1'b1;
      @(negedge clk);
      check("flush full out_valid", {31'b0, out_valid}, 32'd0);
      check("flush full in_ready", {31'b0, in_ready}, 32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("flushed stays empty", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset in the middle of a clock period while in ONE.
      out_ready = 1'b0; in_valid = 1'b1;
      drive(32'h40000033, 32'h0, 32'd5, 32'd3);
      @(negedge clk);
      check("async pre one", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async out_valid", {31'b0, out_valid}, 32'd0);
      check("async in_ready", {31'b0, in_ready}, 32'd1);
      check("async op1", op1, 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("async after", {31'b0, out_valid}, 32'd0);

      // Randomized traffic against the queue model.
      q.delete();
      for (int cyc = 0; cyc < 800; cyc++) begin
         logic [6:0]  opcs[10];
         logic [31:0] ri;
         bit          acc, pop;
         opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F};
         check($sformatf("rnd%0d out_valid", cyc), {31'b0, out_valid}, {31'b0, q.size() != 0});
         check($sformatf("rnd%0d in_ready", cyc), {31'b0, in_ready}, {31'b0, q.size() < 2});
         if (q.size() != 0) begin
            check($sformatf("rnd%0d op1", cyc), op1, q[0].op1);
            check($sformatf("rnd%0d op2", cyc), op2, q[0].op2);
            check($sformatf("rnd%0d op", cyc), {28'b0, op}, {28'b0, q[0].op});
            check($sformatf("rnd%0d illegal", cyc), {31'b0, ill}, {31'b0, q[0].ill});
         end
         ri = $urandom;
         ri[6:0] = opcs[$urandom_range(0, 9)];
         case ($urandom_range(0, 2))
            0: ri[31:25] = 7'h00;
            1: ri[31:25] = 7'h20;
            default: ;
         endcase
         drive(ri, $urandom, $urandom, $urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         acc = in_valid && (q.size() < 2);
         pop = (q.size() != 0) && out_ready;
         if (flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_model(instr, pc, rs1, rs2));
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
